// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU issue controller.
//   fpu_op_e       : 2-bit opcode (ADD, SUB, MUL, NOP)
//   reg_idx_t      : 4-bit FP register index
//   issue_state_e  : issue FSM states
//   *_LAT_DEFAULT  : default unit latencies, start pulse to write enable
package fpu_pkg;

    localparam int unsigned REG_W           = 4;
    localparam int unsigned NUM_REGS        = 16;
    localparam int unsigned ADD_LAT_DEFAULT = 3;
    localparam int unsigned MUL_LAT_DEFAULT = 4;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_NOP = 2'd3
    } fpu_op_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } issue_state_e;

    // One-hot mask selecting a single register.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t idx);
        return NUM_REGS'(1) << idx;
    endfunction

endpackage

// File: rtl/fpu_issue_ctrl_if.sv
// Instruction, unit-control and writeback signals of the FPU issue controller.
//   master : instruction source / execution units / register-file side
//   slave  : the issue controller
interface fpu_issue_ctrl_if;
    import fpu_pkg::*;

    // instruction handshake
    logic     instr_valid;
    fpu_op_e  instr_op;
    reg_idx_t instr_src_a;
    reg_idx_t instr_src_b;
    reg_idx_t instr_dest;
    logic     instr_ready;

    // issue to units
    reg_idx_t rf_raddr_a;
    reg_idx_t rf_raddr_b;
    logic     add_new_instr;
    logic     add_sub;
    logic     mul_new_instr;
    reg_idx_t dest_out;

    // unit writeback
    logic     add_we;
    logic     mul_we;
    reg_idx_t add_reg_dest;
    reg_idx_t mul_reg_dest;
    logic     rf_we;
    reg_idx_t rf_waddr;
    logic     wb_sel;

    // drain / status
    logic     drain;
    logic     drain_done;
    logic     wb_collision;

    modport master (
        output instr_valid, instr_op, instr_src_a, instr_src_b, instr_dest,
        output add_we, mul_we, add_reg_dest, mul_reg_dest, drain,
        input  instr_ready, rf_raddr_a, rf_raddr_b, add_new_instr, add_sub,
        input  mul_new_instr, dest_out, rf_we, rf_waddr, wb_sel,
        input  drain_done, wb_collision
    );

    modport slave (
        input  instr_valid, instr_op, instr_src_a, instr_src_b, instr_dest,
        input  add_we, mul_we, add_reg_dest, mul_reg_dest, drain,
        output instr_ready, rf_raddr_a, rf_raddr_b, add_new_instr, add_sub,
        output mul_new_instr, dest_out, rf_we, rf_waddr, wb_sel,
        output drain_done, wb_collision
    );

endinterface

// File: rtl/fpu_scoreboard.sv
// 16-entry busy scoreboard for FP destination registers.
//   clk, reset          : clock, synchronous active-high reset
//   set_en/set_idx      : mark a register busy (issue)
//   clr_en/clr_idx      : mark a register free (writeback)
//   rd_a/rd_b/rd_d      : lookup indices
//   busy_a_c/b_c/d_c    : current busy bit of each lookup (combinational)
//   busy_next_c         : busy vector after this cycle's set/clear (combinational)
// A set and a clear of the same register in one cycle leaves it busy.
module fpu_scoreboard
    import fpu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                set_en,
    input  reg_idx_t            set_idx,
    input  logic                clr_en,
    input  reg_idx_t            clr_idx,
    input  reg_idx_t            rd_a,
    input  reg_idx_t            rd_b,
    input  reg_idx_t            rd_d,
    output logic                busy_a_c,
    output logic                busy_b_c,
    output logic                busy_d_c,
    output logic [NUM_REGS-1:0] busy_next_c
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] set_mask;
    logic [NUM_REGS-1:0] clr_mask;

    // Next busy vector: clear first, then set, so a same-cycle set wins.
    always_comb begin
        set_mask    = '0;
        clr_mask    = '0;
        if (set_en) set_mask = reg_onehot(set_idx);
        if (clr_en) clr_mask = reg_onehot(clr_idx);
        busy_next_c = (busy_q & ~clr_mask) | set_mask;
        busy_a_c    = busy_q[rd_a];
        busy_b_c    = busy_q[rd_b];
        busy_d_c    = busy_q[rd_d];
    end

    always_ff @(posedge clk) begin
        if (reset) busy_q <= '0;
        else       busy_q <= busy_next_c;
    end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// In-order issue controller for an FPU with separate add/sub and multiply units.
// Accepts one instruction per cycle, stalls on RAW/WAW hazards via a register
// scoreboard and on writeback-port conflicts via a reservation shift vector,
// emits registered start pulses, merges unit writebacks and supports draining.
//   clk, reset : clock, synchronous active-high reset
//   bus        : fpu_issue_ctrl_if.slave (instruction, issue, writeback, drain)
// Parameters : ADD_LAT / MUL_LAT = cycles from start pulse to unit write enable
//              (1 <= ADD_LAT <= MUL_LAT).
// Build macro: FPU_WB_BYPASS_EN - when defined, a source register being
//              written back this cycle does not stall issue.
module fpu_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int unsigned ADD_LAT = ADD_LAT_DEFAULT,
    parameter int unsigned MUL_LAT = MUL_LAT_DEFAULT
)(
    input  logic            clk,
    input  logic            reset,
    fpu_issue_ctrl_if.slave bus
);

    // resv_q[k] = writeback port reserved k+1 cycles from now.
    localparam int unsigned      RESV_W   = MUL_LAT + 1;
    localparam logic [RESV_W-1:0] ADD_SLOT = RESV_W'(1) << (ADD_LAT - 1);
    localparam logic [RESV_W-1:0] MUL_SLOT = RESV_W'(1) << (MUL_LAT - 1);

    issue_state_e        state_q;
    logic [RESV_W-1:0]   resv_q;
    logic [RESV_W-1:0]   resv_d;
    logic [NUM_REGS-1:0] busy_next;
    logic                busy_a;
    logic                busy_b;
    logic                busy_d;
    logic                stall_a;
    logic                stall_b;
    logic                slot_taken;
    logic                is_nop;
    logic                is_mul;
    logic                is_add;
    logic                accept;
    logic                issue_add;
    logic                issue_mul;
    logic                pipe_empty_next;

    // Writeback merge: mul wins on a collision.
    always_comb begin
        bus.rf_we    = 1'b0;
        bus.wb_sel   = 1'b0;
        bus.rf_waddr = '0;
        if (!reset) begin
            bus.rf_we  = bus.add_we | bus.mul_we;
            bus.wb_sel = bus.mul_we;
            if (bus.mul_we)      bus.rf_waddr = bus.mul_reg_dest;
            else if (bus.add_we) bus.rf_waddr = bus.add_reg_dest;
        end
    end

    fpu_scoreboard u_scoreboard (
        .clk         (clk),
        .reset       (reset),
        .set_en      (issue_add | issue_mul),
        .set_idx     (bus.instr_dest),
        .clr_en      (bus.rf_we),
        .clr_idx     (bus.rf_waddr),
        .rd_a        (bus.instr_src_a),
        .rd_b        (bus.instr_src_b),
        .rd_d        (bus.instr_dest),
        .busy_a_c    (busy_a),
        .busy_b_c    (busy_b),
        .busy_d_c    (busy_d),
        .busy_next_c (busy_next)
    );

    // Source stall: optionally forgive a source that is retiring this cycle.
    always_comb begin
`ifdef FPU_WB_BYPASS_EN
        stall_a = busy_a & ~(bus.rf_we && (bus.rf_waddr == bus.instr_src_a));
        stall_b = busy_b & ~(bus.rf_we && (bus.rf_waddr == bus.instr_src_b));
`else
        stall_a = busy_a;
        stall_b = busy_b;
`endif
    end

    // Issue decision and reservation update.
    always_comb begin
        is_nop     = (bus.instr_op == OP_NOP);
        is_mul     = (bus.instr_op == OP_MUL);
        is_add     = (bus.instr_op == OP_ADD) || (bus.instr_op == OP_SUB);
        // An op accepted now writes back LAT+1 cycles from now, i.e. resv_q[LAT].
        slot_taken = is_mul ? resv_q[MUL_LAT] : resv_q[ADD_LAT];

        bus.instr_ready = !reset && (state_q == ST_RUN) &&
                          (is_nop || !(stall_a || stall_b || busy_d || slot_taken));

        accept    = bus.instr_valid && bus.instr_ready;
        issue_add = accept && is_add;
        issue_mul = accept && is_mul;

        resv_d = resv_q >> 1;
        if (issue_add) resv_d = resv_d | ADD_SLOT;
        if (issue_mul) resv_d = resv_d | MUL_SLOT;

        pipe_empty_next = (busy_next == '0) && (resv_d == '0);
    end

    // Issue pipeline registers and sticky collision flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            resv_q            <= '0;
            bus.add_new_instr <= 1'b0;
            bus.add_sub       <= 1'b0;
            bus.mul_new_instr <= 1'b0;
            bus.dest_out      <= '0;
            bus.rf_raddr_a    <= '0;
            bus.rf_raddr_b    <= '0;
            bus.wb_collision  <= 1'b0;
        end else begin
            resv_q            <= resv_d;
            bus.add_new_instr <= issue_add;
            bus.add_sub       <= issue_add && (bus.instr_op == OP_SUB);
            bus.mul_new_instr <= issue_mul;
            if (issue_add || issue_mul) begin
                bus.dest_out   <= bus.instr_dest;
                bus.rf_raddr_a <= bus.instr_src_a;
                bus.rf_raddr_b <= bus.instr_src_b;
            end
            if (bus.add_we && bus.mul_we) bus.wb_collision <= 1'b1;
        end
    end

    // Drain FSM; DONE is entered as soon as the pipeline will be empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_RUN;
            bus.drain_done <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    bus.drain_done <= 1'b0;
                    if (bus.drain) state_q <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (pipe_empty_next) begin
                        state_q        <= ST_DONE;
                        bus.drain_done <= 1'b1;
                    end else begin
                        bus.drain_done <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (!bus.drain) begin
                        state_q        <= ST_RUN;
                        bus.drain_done <= 1'b0;
                    end else begin
                        bus.drain_done <= 1'b1;
                    end
                end
                default: begin
                    state_q        <= ST_RUN;
                    bus.drain_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed self-checking bench for fpu_issue_ctrl with simple latency models
// of the add and multiply units driving write enables back into the controller.
module tb_fpu_issue_ctrl;
    import fpu_pkg::*;

    localparam int unsigned ADD_LAT = 3;
    localparam int unsigned MUL_LAT = 4;

    logic tb_clk;
    logic reset;
    int   checks;
    int   errors;

    fpu_issue_ctrl_if bus();

    fpu_issue_ctrl #(.ADD_LAT(ADD_LAT), .MUL_LAT(MUL_LAT)) dut (
        .clk   (tb_clk),
        .reset (reset),
        .bus   (bus)
    );

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    // Unit models: write enable ADD_LAT / MUL_LAT cycles after the start pulse.
    logic [ADD_LAT-1:0] add_v;
    logic [MUL_LAT-1:0] mul_v;
    reg_idx_t           add_d [ADD_LAT];
    reg_idx_t           mul_d [MUL_LAT];
    logic               frc_en;
    logic               frc_add_we;
    logic               frc_mul_we;
    reg_idx_t           frc_add_dest;
    reg_idx_t           frc_mul_dest;

    always @(posedge tb_clk) begin
        if (reset) begin
            add_v <= '0;
            mul_v <= '0;
        end else begin
            add_v <= {add_v[ADD_LAT-2:0], bus.add_new_instr};
            mul_v <= {mul_v[MUL_LAT-2:0], bus.mul_new_instr};
        end
        add_d[0] <= bus.dest_out;
        mul_d[0] <= bus.dest_out;
        for (int k = 1; k < ADD_LAT; k++) add_d[k] <= add_d[k-1];
        for (int k = 1; k < MUL_LAT; k++) mul_d[k] <= mul_d[k-1];
    end

    assign bus.add_we       = frc_en ? frc_add_we   : add_v[ADD_LAT-1];
    assign bus.mul_we       = frc_en ? frc_mul_we   : mul_v[MUL_LAT-1];
    assign bus.add_reg_dest = frc_en ? frc_add_dest : add_d[ADD_LAT-1];
    assign bus.mul_reg_dest = frc_en ? frc_mul_dest : mul_d[MUL_LAT-1];

    task automatic step();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic drive(input logic v, input fpu_op_e op, input reg_idx_t a,
                         input reg_idx_t b, input reg_idx_t d);
        bus.instr_valid = v;
        bus.instr_op    = op;
        bus.instr_src_a = a;
        bus.instr_src_b = b;
        bus.instr_dest  = d;
    endtask

    task automatic idle(input int n);
        drive(1'b0, OP_NOP, 4'd0, 4'd0, 4'd0);
        repeat (n) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.drain = 1'b0;
        frc_en = 1'b0; frc_add_we = 1'b0; frc_mul_we = 1'b0;
        frc_add_dest = '0; frc_mul_dest = '0;
        drive(1'b1, OP_NOP, 4'd0, 4'd0, 4'd0);
        repeat (3) step();
        settle();
        checks++; if (bus.instr_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_in_reset got=%0b exp=0", bus.instr_ready); end
        step();
        reset = 1'b0;
        settle();
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%0b exp=1", bus.instr_ready); end
        checks++; if (bus.add_new_instr !== 1'b0) begin errors++; $display("FAIL rst_add_pulse got=%0b exp=0", bus.add_new_instr); end
        checks++; if (bus.mul_new_instr !== 1'b0) begin errors++; $display("FAIL rst_mul_pulse got=%0b exp=0", bus.mul_new_instr); end
        checks++; if (bus.drain_done !== 1'b0) begin errors++; $display("FAIL rst_drain_done got=%0b exp=0", bus.drain_done); end
        checks++; if (bus.wb_collision !== 1'b0) begin errors++; $display("FAIL rst_collision got=%0b exp=0", bus.wb_collision); end
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL rst_rf_we got=%0b exp=0", bus.rf_we); end
        checks++; if (bus.dest_out !== 4'd0) begin errors++; $display("FAIL rst_dest_out got=%0d exp=0", bus.dest_out); end
        idle(1);
    endtask

    // ADD r3<-r1,r2 then dependent SUB r4<-r3,r1.
    task automatic test_add_raw();
        step(); drive(1'b1, OP_ADD, 4'd1, 4'd2, 4'd3); settle();
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL add_accept got=%0b exp=1", bus.instr_ready); end
        step(); drive(1'b1, OP_SUB, 4'd3, 4'd1, 4'd4); settle();
        checks++; if (bus.add_new_instr !== 1'b1) begin errors++; $display("FAIL add_pulse got=%0b exp=1", bus.add_new_instr); end
        checks++; if (bus.add_sub !== 1'b0) begin errors++; $display("FAIL add_sub_flag got=%0b exp=0", bus.add_sub); end
        checks++; if (bus.dest_out !== 4'd3) begin errors++; $display("FAIL add_dest_out got=%0d exp=3", bus.dest_out); end
        checks++; if (bus.rf_raddr_a !== 4'd1 || bus.rf_raddr_b !== 4'd2) begin errors++; $display("FAIL add_raddr got=%0d,%0d exp=1,2", bus.rf_raddr_a, bus.rf_raddr_b); end
        checks++; if (bus.mul_new_instr !== 1'b0) begin errors++; $display("FAIL add_no_mul got=%0b exp=0", bus.mul_new_instr); end
        checks++; if (bus.instr_ready !== 1'b0) begin errors++; $display("FAIL raw_stall_c1 got=%0b exp=0", bus.instr_ready); end
        step(); settle();
        checks++; if (bus.add_new_instr !== 1'b0) begin errors++; $display("FAIL add_pulse_width got=%0b exp=0", bus.add_new_instr); end
        checks++; if (bus.instr_ready !== 1'b0) begin errors++; $display("FAIL raw_stall_c2 got=%0b exp=0", bus.instr_ready); end
        step(); settle();
        checks++; if (bus.instr_ready !== 1'b0) begin errors++; $display("FAIL raw_stall_c3 got=%0b exp=0", bus.instr_ready); end
        step(); settle();
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'd3 || bus.wb_sel !== 1'b0) begin errors++; $display("FAIL add_wb got=%0b/%0d/%0b exp=1/3/0", bus.rf_we, bus.rf_waddr, bus.wb_sel); end
`ifdef FPU_WB_BYPASS_EN
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL sub_bypass_accept got=%0b exp=1", bus.instr_ready); end
`else
        checks++; if (bus.instr_ready !== 1'b0) begin errors++; $display("FAIL sub_wb_cycle_stall got=%0b exp=0", bus.instr_ready); end
        step(); settle();
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL sub_accept_after_wb got=%0b exp=1", bus.instr_ready); end
`endif
        step(); drive(1'b0, OP_NOP, 4'd0, 4'd0, 4'd0); settle();
        checks++; if (bus.add_new_instr !== 1'b1 || bus.add_sub !== 1'b1) begin errors++; $display("FAIL sub_pulse got=%0b/%0b exp=1/1", bus.add_new_instr, bus.add_sub); end
        checks++; if (bus.dest_out !== 4'd4 || bus.rf_raddr_a !== 4'd3) begin errors++; $display("FAIL sub_dest got=%0d/%0d exp=4/3", bus.dest_out, bus.rf_raddr_a); end
        idle(8);
    endtask

    // NOP is always accepted and leaves no trace.
    task automatic test_nop();
        step(); drive(1'b1, OP_ADD, 4'd1, 4'd2, 4'd3); settle();
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL nop_pre_add got=%0b exp=1", bus.instr_ready); end
        step(); drive(1'b1, OP_NOP, 4'd3, 4'd3, 4'd11); settle();
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL nop_ready_busy got=%0b exp=1", bus.instr_ready); end
        step(); drive(1'b1, OP_ADD, 4'd5, 4'd6, 4'd11); settle();
        checks++; if (bus.add_new_instr !== 1'b0 || bus.mul_new_instr !== 1'b0) begin errors++; $display("FAIL nop_no_pulse got=%0b/%0b exp=0/0", bus.add_new_instr, bus.mul_new_instr); end
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL nop_no_busy got=%0b exp=1", bus.instr_ready); end
        idle(8);
    endtask

    // MUL r5 then ADD r6 one cycle later would land on the same writeback cycle.
    task automatic test_wb_slot();
        step(); drive(1'b1, OP_MUL, 4'd7, 4'd8, 4'd5); settle();
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL mul_accept got=%0b exp=1", bus.instr_ready); end
        step(); drive(1'b1, OP_ADD, 4'd9, 4'd10, 4'd6); settle();
        checks++; if (bus.mul_new_instr !== 1'b1 || bus.dest_out !== 4'd5) begin errors++; $display("FAIL mul_pulse got=%0b/%0d exp=1/5", bus.mul_new_instr, bus.dest_out); end
        checks++; if (bus.instr_ready !== 1'b0) begin errors++; $display("FAIL slot_stall got=%0b exp=0", bus.instr_ready); end
        step(); settle();
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL slot_accept got=%0b exp=1", bus.instr_ready); end
        step(); drive(1'b0, OP_NOP, 4'd0, 4'd0, 4'd0); settle();
        checks++; if (bus.add_new_instr !== 1'b1 || bus.dest_out !== 4'd6) begin errors++; $display("FAIL slot_add_pulse got=%0b/%0d exp=1/6", bus.add_new_instr, bus.dest_out); end
        step(); settle();
        checks++; if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL slot_c4_idle got=%0b exp=0", bus.rf_we); end
        step(); settle();
        checks++; if (bus.rf_we !== 1'b1 || bus.wb_sel !== 1'b1 || bus.rf_waddr !== 4'd5) begin errors++; $display("FAIL slot_mul_wb got=%0b/%0b/%0d exp=1/1/5", bus.rf_we, bus.wb_sel, bus.rf_waddr); end
        checks++; if (bus.add_we !== 1'b0) begin errors++; $display("FAIL slot_no_overlap got=%0b exp=0", bus.add_we); end
        step(); settle();
        checks++; if (bus.rf_we !== 1'b1 || bus.wb_sel !== 1'b0 || bus.rf_waddr !== 4'd6) begin errors++; $display("FAIL slot_add_wb got=%0b/%0b/%0d exp=1/0/6", bus.rf_we, bus.wb_sel, bus.rf_waddr); end
        step(); settle();
        checks++; if (bus.wb_collision !== 1'b0) begin errors++; $display("FAIL slot_no_collision got=%0b exp=0", bus.wb_collision); end
        idle(2);
    endtask

    // Forced simultaneous writebacks.
    task automatic test_collision();
        step();
        frc_en = 1'b1; frc_add_we = 1'b1; frc_mul_we = 1'b1;
        frc_add_dest = 4'd1; frc_mul_dest = 4'd2;
        settle();
        checks++; if (bus.wb_sel !== 1'b1 || bus.rf_waddr !== 4'd2 || bus.rf_we !== 1'b1) begin errors++; $display("FAIL coll_mux got=%0b/%0d/%0b exp=1/2/1", bus.wb_sel, bus.rf_waddr, bus.rf_we); end
        step(); frc_en = 1'b0; settle();
        checks++; if (bus.wb_collision !== 1'b1) begin errors++; $display("FAIL coll_set got=%0b exp=1", bus.wb_collision); end
        repeat (3) step();
        settle();
        checks++; if (bus.wb_collision !== 1'b1) begin errors++; $display("FAIL coll_sticky got=%0b exp=1", bus.wb_collision); end
    endtask

    // Two ops in flight, drain asserted in the cycle the second is accepted.
    task automatic test_drain();
        step(); drive(1'b1, OP_ADD, 4'd2, 4'd3, 4'd1); settle();
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL drn_add_accept got=%0b exp=1", bus.instr_ready); end
        step(); drive(1'b1, OP_MUL, 4'd8, 4'd9, 4'd7); bus.drain = 1'b1; settle();
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL drn_accept_with_drain got=%0b exp=1", bus.instr_ready); end
        step(); drive(1'b1, OP_NOP, 4'd0, 4'd0, 4'd0); settle();
        checks++; if (bus.mul_new_instr !== 1'b1) begin errors++; $display("FAIL drn_mul_issued got=%0b exp=1", bus.mul_new_instr); end
        checks++; if (bus.instr_ready !== 1'b0) begin errors++; $display("FAIL drn_blocks got=%0b exp=0", bus.instr_ready); end
        for (int c = 3; c <= 6; c++) begin
            step(); settle();
            checks++; if (bus.drain_done !== 1'b0 || bus.instr_ready !== 1'b0) begin errors++; $display("FAIL drn_busy_c%0d got=%0b/%0b exp=0/0", c, bus.drain_done, bus.instr_ready); end
        end
        checks++; if (bus.rf_we !== 1'b1 || bus.rf_waddr !== 4'd7) begin errors++; $display("FAIL drn_last_wb got=%0b/%0d exp=1/7", bus.rf_we, bus.rf_waddr); end
        step(); bus.drain = 1'b0; settle();
        checks++; if (bus.drain_done !== 1'b1) begin errors++; $display("FAIL drn_done got=%0b exp=1", bus.drain_done); end
        checks++; if (bus.instr_ready !== 1'b0) begin errors++; $display("FAIL drn_done_not_ready got=%0b exp=0", bus.instr_ready); end
        step(); settle();
        checks++; if (bus.instr_ready !== 1'b1 || bus.drain_done !== 1'b0) begin errors++; $display("FAIL drn_back_to_run got=%0b/%0b exp=1/0", bus.instr_ready, bus.drain_done); end
        idle(2);
    endtask

    // Reset with ops in flight discards all bookkeeping.
    task automatic test_reset_midop();
        step(); drive(1'b1, OP_ADD, 4'd2, 4'd3, 4'd1); settle();
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL mid_add_accept got=%0b exp=1", bus.instr_ready); end
        step(); drive(1'b1, OP_MUL, 4'd4, 4'd5, 4'd2); settle();
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL mid_mul_accept got=%0b exp=1", bus.instr_ready); end
        step(); reset = 1'b1; drive(1'b0, OP_NOP, 4'd0, 4'd0, 4'd0); settle();
        checks++; if (bus.instr_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_in_reset got=%0b exp=0", bus.instr_ready); end
        step(); reset = 1'b0; drive(1'b1, OP_ADD, 4'd1, 4'd2, 4'd3); settle();
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL mid_sb_cleared got=%0b exp=1", bus.instr_ready); end
        checks++; if (bus.add_new_instr !== 1'b0 || bus.mul_new_instr !== 1'b0) begin errors++; $display("FAIL mid_pulses got=%0b/%0b exp=0/0", bus.add_new_instr, bus.mul_new_instr); end
        checks++; if (bus.wb_collision !== 1'b0) begin errors++; $display("FAIL mid_collision_clr got=%0b exp=0", bus.wb_collision); end
        step(); drive(1'b0, OP_NOP, 4'd0, 4'd0, 4'd0); settle();
        checks++; if (bus.add_new_instr !== 1'b1 || bus.dest_out !== 4'd3) begin errors++; $display("FAIL mid_reissue got=%0b/%0d exp=1/3", bus.add_new_instr, bus.dest_out); end
        idle(6);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_add_raw();
        test_nop();
        test_wb_slot();
        test_collision();
        test_drain();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fpu_issue_ctrl.md
FPU_ISSUE_CTRL -- requirements
Module: fpu_issue_ctrl

Interface
REQ-001 SHALL use one clock and one reset; reset is synchronous and active-high.
REQ-002 Ports (name  dir  width  meaning):
- clk  in  1  clock
- reset  in  1  sync active-high reset
- instr_valid  in  1  instruction offered
- instr_op  in  2  opcode: ADD, SUB, MUL, NOP
- instr_src_a, instr_src_b, instr_dest  in  4 each  FP register indices
- instr_ready  out  1  instruction accepted this cycle
- rf_raddr_a, rf_raddr_b  out  4 each  register-file read addresses
- add_new_instr  out  1  one-cycle start pulse, add/subtract unit
- add_sub  out  1  1 = subtract
- mul_new_instr  out  1  one-cycle start pulse, multiply unit
- dest_out  out  4  destination to issued unit
- add_we, mul_we  in  1 each  unit write_enable
- add_reg_dest, mul_reg_dest  in  4 each  unit reg_dest
- rf_we  out  1  register-file write strobe
- rf_waddr  out  4  write address
- wb_sel  out  1  0 = add result, 1 = mul result
- drain  in  1  stop issue and empty pipeline
- drain_done  out  1  pipeline empty while draining
- wb_collision  out  1  sticky error flag
REQ-003 Parameters (name, default, meaning): ADD_LAT, 3, cycles from start pulse to add_we; MUL_LAT, 4, same for multiply.

Function
REQ-004 SHALL accept an instruction on the cycle instr_valid && instr_ready, and issue it in that same cycle (combinational instr_ready, registered start pulses asserted one cycle later).
REQ-005 SHALL keep a 16-bit scoreboard; the dest bit is set on issue and cleared when rf_we writes that address.
REQ-006 SHALL deassert instr_ready if src_a, src_b or dest is busy (RAW/WAW stall).
REQ-007 SHALL keep a writeback reservation vector of MUL_LAT+1 bits, shifted one position per cycle; an issue with latency L SHALL be stalled if a writeback is already reserved L+1 cycles after acceptance.
REQ-008 SHALL issue NOP with instr_ready=1, no start pulse and no scoreboard change.
REQ-009 SHALL drive rf_we = add_we | mul_we, wb_sel = mul_we, rf_waddr from the selected unit.
REQ-010 SHALL set wb_collision when add_we && mul_we, hold it until reset, and select mul in that cycle.
REQ-011 FSM states: RUN (issue allowed), DRAIN (instr_ready=0), DONE (drain_done=1).
- RUN->DRAIN on drain=1.
- DRAIN->DONE when scoreboard and reservation vector are zero.
- DONE->RUN on drain=0.
- drain in the cycle of an accept: the instruction issues, then DRAIN is entered.
REQ-012 Simultaneous writeback clear and new issue to the same dest: the set SHALL win.

Reset
REQ-013 On reset: state RUN, scoreboard and reservation vector zero, all outputs 0, wb_collision cleared. This applies also mid-operation, discarding in-flight bookkeeping.

Configuration
REQ-014 Macro FPU_WB_BYPASS_EN:
- defined: a source whose busy bit is being cleared this cycle by rf_we SHALL NOT stall.
- undefined: issue waits one more cycle after writeback.

Structure
REQ-015 Package fpu_pkg SHALL hold the opcode enum, the 4-bit reg_idx_t typedef, and the ADD_LAT/MUL_LAT default constants.
REQ-016 Sub-module fpu_scoreboard (set/clear/busy-lookup) SHALL be instantiated once.

Verification
REQ-017 ADD r3<-r1,r2 at cycle 0 -> add_new_instr at cycle 1, add_sub=0, dest_out=3; busy[3] set until add_we with add_reg_dest=3.
REQ-018 ADD r3 followed by SUB r4<-r3,r1 -> instr_ready=0 until the r3 writeback. SUB accepted in the writeback cycle with FPU_WB_BYPASS_EN defined, one cycle later without it.
REQ-019 MUL r5 at cycle 0, then ADD r6 at cycle 1 (both land at the same cycle) -> ADD stalled one cycle; rf_we never sees simultaneous writes; wb_collision stays 0.
REQ-020 Force add_we=mul_we=1 -> wb_collision=1, wb_sel=1; the flag persists until reset.
REQ-021 Two ops in flight, then drain=1 -> instr_ready=0; drain_done=1 one cycle after the last writeback; returns to RUN on drain=0.
REQ-022 reset asserted with ops in flight -> next cycle scoreboard zero, instr_ready=1, all pulses 0.
